// File: rtl/vout_timing_ctrl_if.sv
// Host configuration bus for the video output timing controller.
// Single-cycle register writes; reads return data the following cycle.
interface vout_timing_ctrl_if;
  logic        cfg_we;
  logic        cfg_re;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;

  modport master (
    output cfg_we,
    output cfg_re,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we,
    input  cfg_re,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_rdata
  );
endinterface

// File: rtl/vout_timing_ctrl.sv
// Run-time controller for the video timing generator: staged timing
// parameters are committed by the host and applied on frame boundaries.
module vout_timing_ctrl #(
  parameter int HFP_WIDTH     = 8,
  parameter int HSW_WIDTH     = 4,
  parameter int HBP_WIDTH     = 8,
  parameter int HACTIVE_WIDTH = 16,
  parameter int VFP_WIDTH     = 8,
  parameter int VSW_WIDTH     = 4,
  parameter int VBP_WIDTH     = 8,
  parameter int VACTIVE_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  vout_timing_ctrl_if.slave        cfg,
  input  logic                     de_i,
  output logic                     sync_en_o,
  output logic                     hpol_o,
  output logic [HFP_WIDTH-1:0]     hfp_o,
  output logic [HSW_WIDTH-1:0]     hsw_o,
  output logic [HBP_WIDTH-1:0]     hbp_o,
  output logic [HACTIVE_WIDTH-1:0] hactive_o,
  output logic [VFP_WIDTH-1:0]     vfp_o,
  output logic [VSW_WIDTH-1:0]     vsw_o,
  output logic [VBP_WIDTH-1:0]     vbp_o,
  output logic [VACTIVE_WIDTH-1:0] vactive_o,
  output logic                     frame_done_o,
  output logic                     cfg_err_o
);

  localparam logic [3:0] A_CTRL    = 4'h0;
  localparam logic [3:0] A_HFP     = 4'h1;
  localparam logic [3:0] A_HSW     = 4'h2;
  localparam logic [3:0] A_HBP     = 4'h3;
  localparam logic [3:0] A_HACTIVE = 4'h4;
  localparam logic [3:0] A_VFP     = 4'h5;
  localparam logic [3:0] A_VSW     = 4'h6;
  localparam logic [3:0] A_VBP     = 4'h7;
  localparam logic [3:0] A_VACTIVE = 4'h8;
  localparam logic [3:0] A_COMMIT  = 4'h9;
  localparam logic [3:0] A_STATUS  = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    STOP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                     ctrl_en;
  logic                     s_hpol;
  logic [HFP_WIDTH-1:0]     s_hfp;
  logic [HSW_WIDTH-1:0]     s_hsw;
  logic [HBP_WIDTH-1:0]     s_hbp;
  logic [HACTIVE_WIDTH-1:0] s_hactive;
  logic [VFP_WIDTH-1:0]     s_vfp;
  logic [VSW_WIDTH-1:0]     s_vsw;
  logic [VBP_WIDTH-1:0]     s_vbp;
  logic [VACTIVE_WIDTH-1:0] s_vactive;

  logic                     pending;
  logic                     de_d;
  logic [VACTIVE_WIDTH-1:0] line_cnt;
  logic [VACTIVE_WIDTH-1:0] line_inc;
  logic [7:0]               frame_cnt;
  logic [15:0]              rdata_d;

  logic running;
  logic de_fall;
  logic frame_tick;
  logic commit;
  logic commit_ok;
  logic stat_wr;
  logic apply;

  assign running    = (state_q == RUN) || (state_q == STOP);
  assign sync_en_o  = running;
  assign de_fall    = de_d & ~de_i;
  assign line_inc   = line_cnt + VACTIVE_WIDTH'(1);
  assign frame_tick = running & de_fall & (line_inc == vactive_o);

  assign commit    = cfg.cfg_we && (cfg.cfg_addr == A_COMMIT);
  assign stat_wr   = cfg.cfg_we && (cfg.cfg_addr == A_STATUS);
  assign commit_ok = (s_hactive != '0) && (s_vactive != '0);

  // IDLE/START preload whatever is pending; running only at frame edges
  assign apply = pending &
                 ((state_q == IDLE) | (state_q == START) | frame_tick);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (ctrl_en) state_d = START;
      START: state_d = RUN;
      RUN:   if (!ctrl_en) state_d = STOP;
      STOP: begin
        if (ctrl_en) state_d = RUN;
        else if (frame_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      de_d         <= 1'b0;
      line_cnt     <= '0;
      frame_cnt    <= '0;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      de_d         <= de_i;
      frame_done_o <= frame_tick;
      if (!running) line_cnt <= '0;
      else if (de_fall) line_cnt <= frame_tick ? '0 : line_inc;
      if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // A commit landing on an apply edge re-arms pending for the next frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      if (commit && commit_ok) pending <= 1'b1;
      else if (apply) pending <= 1'b0;
      if (commit && !commit_ok) cfg_err_o <= 1'b1;
      else if (stat_wr) cfg_err_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_en   <= 1'b0;
      s_hpol    <= 1'b0;
      s_hfp     <= '0;
      s_hsw     <= '0;
      s_hbp     <= '0;
      s_hactive <= '0;
      s_vfp     <= '0;
      s_vsw     <= '0;
      s_vbp     <= '0;
      s_vactive <= '0;
    end else if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        A_CTRL: begin
          ctrl_en <= cfg.cfg_wdata[0];
          s_hpol  <= cfg.cfg_wdata[1];
        end
        A_HFP:     s_hfp     <= cfg.cfg_wdata[HFP_WIDTH-1:0];
        A_HSW:     s_hsw     <= cfg.cfg_wdata[HSW_WIDTH-1:0];
        A_HBP:     s_hbp     <= cfg.cfg_wdata[HBP_WIDTH-1:0];
        A_HACTIVE: s_hactive <= cfg.cfg_wdata[HACTIVE_WIDTH-1:0];
        A_VFP:     s_vfp     <= cfg.cfg_wdata[VFP_WIDTH-1:0];
        A_VSW:     s_vsw     <= cfg.cfg_wdata[VSW_WIDTH-1:0];
        A_VBP:     s_vbp     <= cfg.cfg_wdata[VBP_WIDTH-1:0];
        A_VACTIVE: s_vactive <= cfg.cfg_wdata[VACTIVE_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpol_o    <= 1'b0;
      hfp_o     <= '0;
      hsw_o     <= '0;
      hbp_o     <= '0;
      hactive_o <= '0;
      vfp_o     <= '0;
      vsw_o     <= '0;
      vbp_o     <= '0;
      vactive_o <= '0;
    end else if (apply) begin
      hpol_o    <= s_hpol;
      hfp_o     <= s_hfp;
      hsw_o     <= s_hsw;
      hbp_o     <= s_hbp;
      hactive_o <= s_hactive;
      vfp_o     <= s_vfp;
      vsw_o     <= s_vsw;
      vbp_o     <= s_vbp;
      vactive_o <= s_vactive;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (cfg.cfg_addr)
      A_CTRL:    rdata_d = {14'd0, s_hpol, ctrl_en};
      A_HFP:     rdata_d = 16'(s_hfp);
      A_HSW:     rdata_d = 16'(s_hsw);
      A_HBP:     rdata_d = 16'(s_hbp);
      A_HACTIVE: rdata_d = 16'(s_hactive);
      A_VFP:     rdata_d = 16'(s_vfp);
      A_VSW:     rdata_d = 16'(s_vsw);
      A_VBP:     rdata_d = 16'(s_vbp);
      A_VACTIVE: rdata_d = 16'(s_vactive);
      A_STATUS: begin
        rdata_d = {frame_cnt, 5'd0,
                   cfg_err_o, pending, sync_en_o};
      end
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cfg.cfg_rdata <= '0;
    else if (cfg.cfg_re) cfg.cfg_rdata <= rdata_d;
  end

endmodule

// File: tb/tb_vout_timing_ctrl.sv
// Bench for vout_timing_ctrl: register table, frame-boundary apply,
// stop/cancel, commit errors and reset; reads go through a scoreboard.
module tb_vout_timing_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de = 1'b0;
  logic        sync_en, hpol, frame_done, cfg_err;
  logic [7:0]  hfp, hbp, vfp, vbp;
  logic [3:0]  hsw, vsw;
  logic [15:0] hactive, vactive;

  vout_timing_ctrl_if cfg();

  vout_timing_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg),
    .de_i         (de),
    .sync_en_o    (sync_en),
    .hpol_o       (hpol),
    .hfp_o        (hfp),
    .hsw_o        (hsw),
    .hbp_o        (hbp),
    .hactive_o    (hactive),
    .vfp_o        (vfp),
    .vsw_o        (vsw),
    .vbp_o        (vbp),
    .vactive_o    (vactive),
    .frame_done_o (frame_done),
    .cfg_err_o    (cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic [15:0] exp;
  } rd_exp_t;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] e;
  } vec_t;

  rd_exp_t sb[$];
  vec_t    tbl[13];
  logic    rd_v = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_v <= cfg.cfg_re;

  always @(negedge clk) begin
    rd_exp_t x;
    if (rd_v) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %0h expected none",
                 cfg.cfg_rdata);
      end else begin
        x = sb.pop_front();
        chk(x.nm, 32'(cfg.cfg_rdata), 32'(x.exp));
      end
    end
  end

  task automatic push_exp(input string nm, input logic [15:0] e);
    rd_exp_t x;
    x.nm  = nm;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg.cfg_we    = 1'b1;
    cfg.cfg_addr  = a;
    cfg.cfg_wdata = d;
    @(negedge clk);
    cfg.cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e,
                    input string nm);
    @(negedge clk);
    cfg.cfg_re   = 1'b1;
    cfg.cfg_addr = a;
    push_exp(nm, e);
    @(negedge clk);
    cfg.cfg_re = 1'b0;
  endtask

  task automatic wr_rd(input logic [3:0] a, input logic [15:0] d,
                       input logic [15:0] old, input string nm);
    @(negedge clk);
    cfg.cfg_we    = 1'b1;
    cfg.cfg_re    = 1'b1;
    cfg.cfg_addr  = a;
    cfg.cfg_wdata = d;
    push_exp(nm, old);
    @(negedge clk);
    cfg.cfg_we = 1'b0;
    cfg.cfg_re = 1'b0;
  endtask

  // One active line; optionally a register write on the de-fall cycle.
  // Returns on the cycle after the fall is sampled.
  task automatic line(input int n, input bit do_w,
                      input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    de = 1'b1;
    repeat (n - 1) @(negedge clk);
    de = 1'b0;
    if (do_w) begin
      cfg.cfg_we    = 1'b1;
      cfg.cfg_addr  = a;
      cfg.cfg_wdata = d;
    end
    @(negedge clk);
    cfg.cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'h1, 16'h1234, 16'h0034};
    tbl[1]  = '{4'h2, 16'h00ff, 16'h000f};
    tbl[2]  = '{4'h8, 16'hffff, 16'hffff};
    tbl[3]  = '{4'h1, 16'd10,   16'd10};
    tbl[4]  = '{4'h2, 16'd4,    16'd4};
    tbl[5]  = '{4'h3, 16'd6,    16'd6};
    tbl[6]  = '{4'h4, 16'd20,   16'd20};
    tbl[7]  = '{4'h5, 16'd2,    16'd2};
    tbl[8]  = '{4'h6, 16'd1,    16'd1};
    tbl[9]  = '{4'h7, 16'd2,    16'd2};
    tbl[10] = '{4'h8, 16'd3,    16'd3};
    tbl[11] = '{4'hb, 16'h0055, 16'h0000};
    tbl[12] = '{4'h0, 16'h0002, 16'h0002};

    cfg.cfg_we    = 1'b0;
    cfg.cfg_re    = 1'b0;
    cfg.cfg_addr  = 4'h0;
    cfg.cfg_wdata = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_sync_en", 32'(sync_en), 0);
    chk("rst_hactive", 32'(hactive), 0);
    chk("rst_vactive", 32'(vactive), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    rd(4'hA, 16'h0000, "rst_status");

    for (int i = 0; i < 13; i++) begin
      wr(tbl[i].a, tbl[i].d);
      rd(tbl[i].a, tbl[i].e, $sformatf("tbl%0d", i));
    end
    wr_rd(4'h1, 16'h0055, 16'd10, "wr_rd_old");
    rd(4'h1, 16'h0055, "wr_rd_new");
    wr(4'h1, 16'd10);
    chk("no_commit_hfp", 32'(hfp), 0);

    wr(4'h9, 16'h0);
    @(negedge clk);
    chk("pre_hfp", 32'(hfp), 10);
    chk("pre_hsw", 32'(hsw), 4);
    chk("pre_hbp", 32'(hbp), 6);
    chk("pre_hactive", 32'(hactive), 20);
    chk("pre_vfp", 32'(vfp), 2);
    chk("pre_vsw", 32'(vsw), 1);
    chk("pre_vbp", 32'(vbp), 2);
    chk("pre_vactive", 32'(vactive), 3);
    chk("pre_hpol", 32'(hpol), 1);
    rd(4'hA, 16'h0000, "status_idle");
    rd(4'h9, 16'h0000, "commit_reads0");

    wr(4'h0, 16'h0001);
    @(negedge clk);
    chk("start_sync_lo", 32'(sync_en), 0);
    @(negedge clk);
    chk("run_sync_hi", 32'(sync_en), 1);

    line(4, 0, 4'h0, 16'h0);
    chk("l1_fd", 32'(frame_done), 0);
    wr(4'h4, 16'd32);
    wr(4'h9, 16'h0);
    line(4, 0, 4'h0, 16'h0);
    chk("l2_fd", 32'(frame_done), 0);
    chk("l2_hactive_old", 32'(hactive), 20);
    line(4, 0, 4'h0, 16'h0);
    chk("l3_fd", 32'(frame_done), 1);
    chk("l3_hactive_new", 32'(hactive), 32);
    @(negedge clk);
    chk("fd_one_cycle", 32'(frame_done), 0);
    rd(4'hA, 16'h0101, "status_frame1");

    wr(4'h8, 16'd0);
    wr(4'h9, 16'h0);
    chk("err_set", 32'(cfg_err), 1);
    rd(4'hA, 16'h0105, "status_err");
    wr(4'hA, 16'h0);
    chk("err_clr", 32'(cfg_err), 0);
    wr(4'h8, 16'd3);
    chk("err_no_apply", 32'(vactive), 3);

    line(4, 0, 4'h0, 16'h0);
    wr(4'h0, 16'h0000);
    line(4, 0, 4'h0, 16'h0);
    chk("stop_sync_hold", 32'(sync_en), 1);
    chk("stop_l2_fd", 32'(frame_done), 0);
    line(4, 0, 4'h0, 16'h0);
    chk("stop_fd", 32'(frame_done), 1);
    chk("stop_sync_lo", 32'(sync_en), 0);
    rd(4'hA, 16'h0200, "status_stopped");

    wr(4'h0, 16'h0001);
    repeat (2) @(negedge clk);
    chk("rerun_sync", 32'(sync_en), 1);
    line(4, 0, 4'h0, 16'h0);
    wr(4'h0, 16'h0000);
    @(negedge clk);
    chk("cancel_stop_sync", 32'(sync_en), 1);
    line(4, 0, 4'h0, 16'h0);
    wr(4'h0, 16'h0001);
    line(4, 0, 4'h0, 16'h0);
    chk("cancel_fd", 32'(frame_done), 1);
    chk("cancel_fd_sync", 32'(sync_en), 1);
    repeat (3) @(negedge clk);
    chk("cancel_sync_after", 32'(sync_en), 1);
    rd(4'hA, 16'h0301, "status_cancel");

    wr(4'h4, 16'd40);
    wr(4'h9, 16'h0);
    rd(4'hA, 16'h0303, "status_pending");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_sync", 32'(sync_en), 0);
    chk("mrst_hactive", 32'(hactive), 0);
    chk("mrst_vactive", 32'(vactive), 0);
    chk("mrst_hfp", 32'(hfp), 0);
    chk("mrst_fd", 32'(frame_done), 0);
    rst_n = 1'b1;
    rd(4'hA, 16'h0000, "mrst_status");
    rd(4'h4, 16'h0000, "mrst_stage");

    wr(4'h8, 16'd1);
    wr(4'h4, 16'd5);
    wr(4'h0, 16'h0002);
    wr(4'h9, 16'h0);
    @(negedge clk);
    chk("v1_hactive", 32'(hactive), 5);
    chk("v1_vactive", 32'(vactive), 1);
    wr(4'h0, 16'h0003);
    repeat (2) @(negedge clk);
    chk("v1_run", 32'(sync_en), 1);
    wr(4'h4, 16'd7);
    wr(4'h9, 16'h0);
    line(4, 1, 4'h9, 16'h0);
    chk("cmt_fd_fd", 32'(frame_done), 1);
    chk("cmt_fd_hactive", 32'(hactive), 7);
    rd(4'hA, 16'h0103, "cmt_fd_pending");
    line(4, 0, 4'h0, 16'h0);
    chk("cmt_fd2_fd", 32'(frame_done), 1);
    rd(4'hA, 16'h0201, "cmt_fd2_status");
    wr(4'h4, 16'd13);
    wr(4'h9, 16'h0);
    line(4, 1, 4'h4, 16'd15);
    chk("wr_fd_fd", 32'(frame_done), 1);
    chk("wr_fd_hactive", 32'(hactive), 13);
    rd(4'h4, 16'd15, "wr_fd_stage");
    rd(4'hA, 16'h0301, "wr_fd_status");

    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vout_timing_ctrl.md
# vout_timing_ctrl

Run-time controller for the video output timing generator. It holds a register-programmable staging copy of all horizontal and vertical timing parameters, drives the generator's live parameter inputs and `sync_en`, and applies committed parameter sets only at frame boundaries so the output never shows a torn frame. Frame boundaries are found by counting active lines on the generator's `de` output. The block sits between the host configuration bus and the timing generator, in the same clock domain.

## Interface
- HFP_WIDTH, 8, front-porch field width (shared by H and V end sums)
- HSW_WIDTH, 4, hsync width field
- HBP_WIDTH, 8, h back-porch field
- HACTIVE_WIDTH, 16, h active field
- VFP_WIDTH, 8; VSW_WIDTH, 4; VBP_WIDTH, 8; VACTIVE_WIDTH, 16, vertical equivalents
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- cfg_we  in  1  register write strobe, one write per cycle
- cfg_re  in  1  register read strobe
- cfg_addr  in  4  register address
- cfg_wdata  in  16  write data; fields use their low bits
- cfg_rdata  out  16  read data, registered, valid the cycle after cfg_re
- de_i  in  1  de from the timing generator
- sync_en_o  out  1  enable to the timing generator
- hpol_o  out  1  active hpol
- hfp_o, hsw_o, hbp_o, hactive_o, vfp_o, vsw_o, vbp_o, vactive_o  out  parameter widths  active timing set
- frame_done_o  out  1  one-cycle pulse at each frame boundary
- cfg_err_o  out  1  sticky error: invalid commit rejected

## Operation
- Register map (staging, read/write): 0 CTRL (bit0 enable, bit1 hpol), 1 HFP, 2 HSW, 3 HBP, 4 HACTIVE, 5 VFP, 6 VSW, 7 VBP, 8 VACTIVE. Address 9 COMMIT is write-only and reads as 0. Address A STATUS is read-only: bit0 running (sync_en_o), bit1 pending, bit2 cfg_err, bits 15:8 frame counter. Writing STATUS clears cfg_err. Unmapped reads return 0; unmapped writes are ignored.
- COMMIT write: if staged HACTIVE≠0 and VACTIVE≠0, set pending. Otherwise leave pending unchanged and set cfg_err.
- Apply: copy all staging fields (including CTRL.hpol) to the active outputs and clear pending. Apply uses staging values as they stood before any same-cycle write.
- FSM states:
  - IDLE: sync_en_o=0, line counter held at 0. CTRL.enable=1 → START.
  - START: apply if pending → RUN. Always exactly one cycle.
  - RUN: sync_en_o=1. CTRL.enable=0 → STOP. On frame_done with pending, apply.
  - STOP: sync_en_o=1. Apply on frame_done if pending, then → IDLE. CTRL.enable=1 again → RUN (cancel stop).
- While IDLE, pending is also applied on the cycle after COMMIT, so the outputs are preloaded.
- Line counter (VACTIVE_WIDTH bits) increments on each de falling edge (de_d & ~de_i, where de_d is a 1-cycle register of de_i) in RUN/STOP. When the increment reaches active vactive, frame_done is asserted and the counter goes to 0.
- Frame counter: 8 bits, increments on each frame_done, wraps 255→0.

## Timing
- Reset values: all outputs 0, all staging and active registers 0, pending 0, state IDLE, de_d 0.
- The cycle after a CTRL write with enable=1 in IDLE is START. sync_en_o rises one cycle after that, i.e. two cycles after the write edge.
- frame_done_o pulses the cycle after the falling de edge is sampled. Applied parameters are visible on the outputs on that same cycle. In STOP, sync_en_o falls on that same cycle.
- COMMIT on the same cycle as frame_done: the current pending set (if any) is applied, and pending stays 1 for the next boundary.
- A write and a read to the same address in one cycle: cfg_rdata returns the old value.
- Active vactive changed by an apply: the new value is compared from the next line onward.
- Reset mid-frame: immediate return to IDLE, sync_en_o=0, no frame_done.

## Test plan
- Reset → all outputs 0, STATUS reads 0x0000.
- In IDLE, write HFP=10, HSW=4, HBP=6, HACTIVE=20, VFP=2, VSW=1, VBP=2, VACTIVE=3, then COMMIT → outputs equal these values one cycle after COMMIT, pending=0. Then write CTRL=1 → sync_en_o=1 two cycles after the write.
- RUN with VACTIVE=3; commit HACTIVE=32 mid-frame → hactive_o stays 20 until the 3rd de falling edge, changes to 32 on the frame_done cycle, STATUS frame count=1.
- COMMIT with staged VACTIVE=0 → pending stays 0 and cfg_err_o=1; a STATUS write clears cfg_err_o.
- CTRL=0 mid-frame → sync_en_o stays 1 until frame_done, then 0, state IDLE. Second case: CTRL=1 rewritten during STOP → sync_en_o never drops.
- rst_n low during RUN with pending=1 → next cycle sync_en_o=0, active fields=0, pending=0.
